// File: rtl/dance_input_ctrl.sv
// dance_input_ctrl: input front end for the LED dance pattern engine.
// Synchronizes and debounces the raw switches and push-buttons, then produces
// enable/mode with a change strobe, a saturating speed level driven by key
// presses, and a one-cycle step tick from a speed-scaled divider.
module dance_input_ctrl #(
    parameter int DEB_CYCLES = 500000,
    parameter int DEB_W      = 19,
    parameter int BASE_DIV   = 6250000,
    parameter int DIV_W      = 23
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [3:0] SW,
    input  logic [1:0] KEY,
    output logic       enable,
    output logic [1:0] mode,
    output logic       mode_valid,
    output logic [1:0] speed,
    output logic       step
);

    // Raw bit layout used internally: {KEY[1:0], SW[3:0]}.
    // Keys are active-low, so their idle (released) level is 1.
    localparam logic [5:0]       IDLE_LEVEL = 6'b110000;
    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DIV_W-1:0] BASE_P     = DIV_W'(BASE_DIV);

    logic [5:0]       r_sync1;
    logic [5:0]       r_sync2;
    logic [5:0]       r_stable;
    logic [DEB_W-1:0] r_deb_cnt [6];
    logic             r_enable;
    logic [1:0]       r_mode;
    logic             r_mode_valid;
    logic [1:0]       r_key_prev;
    logic [1:0]       r_speed;
    logic [DIV_W-1:0] r_div;

    logic [1:0]       w_press;
    logic [1:0]       w_speed_next;
    logic             w_speed_chg;
    logic [DIV_W-1:0] w_period;
    logic             w_run;
    logic             w_div_last;

    // Two-flop synchronizer on every raw input bit.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_sync1 <= IDLE_LEVEL;
            r_sync2 <= IDLE_LEVEL;
        end else begin
            r_sync1 <= {KEY, SW};
            r_sync2 <= r_sync1;
        end
    end

    // Per-bit debounce: accept a new level after DEB_CYCLES consecutive differing samples.
    // NOTE: the counter array is a handful of flops, not a RAM, so resetting it is cheap and keeps startup deterministic.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_stable <= IDLE_LEVEL;
            for (int i = 0; i < 6; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (r_deb_cnt[i] == DEB_LAST) begin
                    r_stable[i]  <= r_sync2[i];
                    r_deb_cnt[i] <= '0;
                end else begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Registered enable/mode; the strobe rises together with the first new value.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_enable     <= 1'b0;
            r_mode       <= 2'd0;
            r_mode_valid <= 1'b0;
        end else begin
            r_enable     <= r_stable[0];
            r_mode       <= r_stable[2:1];
            r_mode_valid <= ({r_stable[0], r_stable[2:1]} != {r_enable, r_mode});
        end
    end

    // Previous debounced key levels, for press (1->0) edge detection.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_key_prev <= 2'b11;
        end else begin
            r_key_prev <= r_stable[5:4];
        end
    end

    assign w_press = r_key_prev & ~r_stable[5:4];

    // Next speed: KEY[0] press raises, KEY[1] press lowers, both together cancel.
    // NOTE: assigning the default first means every path drives the output, so no latch is inferred.
    always_comb begin
        w_speed_next = r_speed;
        case (w_press)
            2'b01:   if (r_speed != 2'd3) w_speed_next = r_speed + 2'd1;
            2'b10:   if (r_speed != 2'd0) w_speed_next = r_speed - 2'd1;
            default: w_speed_next = r_speed;
        endcase
    end

    assign w_speed_chg = (w_speed_next != r_speed);

    // Speed level register; survives enable/freeze changes, cleared only by reset.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_speed <= 2'd0;
        end else begin
            r_speed <= w_speed_next;
        end
    end

    assign w_period   = BASE_P >> r_speed;
    assign w_run      = r_enable & ~r_stable[3];
    assign w_div_last = (r_div == w_period - 1'b1);

    // Step divider: counts 0..P-1 while running, restarts on a speed change or when idle.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_div <= '0;
        end else if (!w_run || w_speed_chg || w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    assign enable     = r_enable;
    assign mode       = r_mode;
    assign mode_valid = r_mode_valid;
    assign speed      = r_speed;
    assign step       = w_run & w_div_last;

endmodule
